// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a program image over the board UART and writes it word by word
//   into the single-port instruction BSRAM. boot_mode stays high, so the
//   top-level address mux selects this loader, until a frame with a valid
//   checksum has been written.
//
//   Frame: 0xA5, N (words, 0..255), N x {low byte, high byte}, CHK
//   CHK = 8-bit sum of the 2N data bytes.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   uart_rx      8N1 serial input, idle high, asynchronous to clk
//   reload       one-cycle pulse; re-enters boot mode from RUN
//   mem_ce       BSRAM chip enable (always 1)
//   mem_wre      BSRAM write enable, one cycle per word
//   mem_ad       BSRAM address (word index, zero-extended)
//   mem_din      BSRAM write data {high byte, low byte}
//   boot_mode    1 while loading; top-level mux select
//   load_done    one-cycle pulse when a valid frame completes
//   err          sticky error flag (checksum or framing), cleared by a sync byte
//   rx_byte_cnt  count of bytes received, wraps at 256
//
// Handshake: the receiver issues byte_valid_q for exactly one cycle with the
// byte in shift_q; the frame FSM has no back-pressure and must consume it in
// that cycle. frm_err_q is a one-cycle pulse, never coincident with byte_valid_q.

module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 234,
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    input  logic              reload,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    output logic              boot_mode,
    output logic              load_done,
    output logic              err,
    output logic [7:0]        rx_byte_cnt
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {F_HUNT, F_LEN, F_LO, F_HI, F_WRITE, F_CHK, F_RUN} fr_state_t;

    // ---------------- receiver ----------------
    logic             rx_meta_q, rx_sync_q;
    rx_state_t        rx_state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic             frm_err_q;
    logic [7:0]       byte_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= R_IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frm_err_q    <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            byte_valid_q <= 1'b0;
            frm_err_q    <= 1'b0;
            case (rx_state_q)
                R_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_q <= R_START;
                        bit_cnt_q  <= '0;
                    end
                end
                R_START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (bit_cnt_q == HALF) begin
                        bit_cnt_q  <= '0;
                        bit_idx_q  <= '0;
                        rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) rx_state_q <= R_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                R_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is seen.
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_q  <= '0;
                        rx_state_q <= R_IDLE;
                        if (rx_sync_q) begin
                            byte_valid_q <= 1'b1;
                            byte_cnt_q   <= byte_cnt_q + 8'd1;
                        end else begin
                            frm_err_q <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- frame parser ----------------
    fr_state_t         fr_state_q;
    logic [7:0]        len_q, idx_q, sum_q, lo_q;
    logic              mem_wre_q, boot_q, done_q, err_q;
    logic [ADDR_W-1:0] mem_ad_q;
    logic [DATA_W-1:0] mem_din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_state_q <= F_HUNT;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            lo_q       <= '0;
            mem_wre_q  <= 1'b0;
            mem_ad_q   <= '0;
            mem_din_q  <= '0;
            boot_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_wre_q <= 1'b0;
            done_q    <= 1'b0;
            if (frm_err_q) begin
                // A framing error aborts a load in progress; once running,
                // the program memory is live and must not be reopened.
                err_q <= 1'b1;
                if (fr_state_q != F_RUN) fr_state_q <= F_HUNT;
            end else begin
                case (fr_state_q)
                    F_HUNT: begin
                        if (byte_valid_q && shift_q == 8'hA5) begin
                            fr_state_q <= F_LEN;
                            err_q      <= 1'b0;
                        end
                    end
                    F_LEN: begin
                        if (byte_valid_q) begin
                            len_q      <= shift_q;
                            idx_q      <= '0;
                            sum_q      <= '0;
                            fr_state_q <= (shift_q == 8'd0) ? F_CHK : F_LO;
                        end
                    end
                    F_LO: begin
                        if (byte_valid_q) begin
                            lo_q       <= shift_q;
                            sum_q      <= sum_q + shift_q;
                            fr_state_q <= F_HI;
                        end
                    end
                    F_HI: begin
                        // Write strobe goes out in the WRITE cycle itself.
                        if (byte_valid_q) begin
                            sum_q      <= sum_q + shift_q;
                            mem_wre_q  <= 1'b1;
                            mem_ad_q   <= ADDR_W'(idx_q);
                            mem_din_q  <= DATA_W'({shift_q, lo_q});
                            fr_state_q <= F_WRITE;
                        end
                    end
                    F_WRITE: begin
                        idx_q      <= idx_q + 8'd1;
                        fr_state_q <= ({1'b0, idx_q} + 9'd1 == {1'b0, len_q}) ? F_CHK : F_LO;
                    end
                    F_CHK: begin
                        if (byte_valid_q) begin
                            if (shift_q == sum_q) begin
                                fr_state_q <= F_RUN;
                                boot_q     <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                fr_state_q <= F_HUNT;
                                err_q      <= 1'b1;
                            end
                        end
                    end
                    F_RUN: begin
                        if (reload) begin
                            fr_state_q <= F_HUNT;
                            boot_q     <= 1'b1;
                            mem_ad_q   <= '0;
                        end
                    end
                    default: fr_state_q <= F_HUNT;
                endcase
            end
        end
    end

    assign mem_ce      = 1'b1;
    assign mem_wre     = mem_wre_q;
    assign mem_ad      = mem_ad_q;
    assign mem_din     = mem_din_q;
    assign boot_mode   = boot_q;
    assign load_done   = done_q;
    assign err         = err_q;
    assign rx_byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: directed frames through a bit-level UART
// driver; a frame-level model predicts writes, load_done, err, boot_mode and
// byte count; every clock (negedge) the DUT outputs are compared against it.
module tb_uart_boot_loader;
  localparam int CPB = 16;
  localparam int AW  = 11;
  localparam int DW  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic uart_rx = 1'b1;
  logic reload = 1'b0;
  logic mem_ce, mem_wre, boot_mode, load_done, err;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_din;
  logic [7:0] rx_byte_cnt;

  always #5 clk = ~clk;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .reload(reload),
    .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_ad(mem_ad), .mem_din(mem_din),
    .boot_mode(boot_mode), .load_done(load_done), .err(err),
    .rx_byte_cnt(rx_byte_cnt)
  );

  // scoreboard / model state
  int n_cmp = 0;
  int n_bad = 0;
  int pend_done = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] fb[$];
  bit m_boot = 1'b1;
  bit m_err = 1'b0;
  logic [7:0] m_cnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // per-cycle comparison against the model
  task automatic cycle_check();
    logic [AW+DW-1:0] e;
    if (rst_n) begin
      check("mem_ce", 32'(mem_ce), 32'd1);
      if (mem_wre) begin
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("write_ad", 32'(mem_ad), 32'(e[AW+DW-1:DW]));
          check("write_din", 32'(mem_din), 32'(e[DW-1:0]));
        end
      end
      if (load_done) begin
        check("load_done_expected", 32'(pend_done > 0), 32'd1);
        if (pend_done > 0) pend_done--;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // frame-level model: positions within the frame decide what each byte means
  task automatic model_byte(input logic [7:0] b);
    int p;
    int n;
    logic [7:0] s;
    m_cnt++;
    if (!m_boot) return;
    if (fb.size() == 0) begin
      if (b == 8'hA5) begin
        fb.push_back(b);
        m_err = 1'b0;
      end
      return;
    end
    fb.push_back(b);
    p = fb.size() - 1;
    n = int'(fb[1]);
    if (p >= 3 && p <= 2*n + 1 && (p % 2) == 1)
      exp_q.push_back({AW'((p - 3) / 2), fb[p], fb[p-1]});
    if (p == 2*n + 2) begin
      s = 8'd0;
      for (int i = 2; i <= 2*n + 1; i++) s += fb[i];
      if (s == b) begin
        m_boot = 1'b0;
        pend_done++;
      end else begin
        m_err = 1'b1;
      end
      fb.delete();
    end
  endtask

  task automatic model_frame_err();
    m_err = 1'b1;
    if (m_boot) fb.delete();
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) model_byte(b);
    else model_frame_err();
    uart_rx = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      ticks(CPB);
    end
    uart_rx = stop;
    ticks(CPB);
    uart_rx = 1'b1;
    if (!stop) ticks(2*CPB);
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic status();
    ticks(3*CPB);
    check("err", 32'(err), 32'(m_err));
    check("boot_mode", 32'(boot_mode), 32'(m_boot));
    check("rx_byte_cnt", 32'(rx_byte_cnt), 32'(m_cnt));
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("done_drained", 32'(pend_done), 32'd0);
  endtask

  task automatic pulse_reload();
    if (!m_boot) begin
      m_boot = 1'b1;
      fb.delete();
    end
    reload = 1'b1;
    tick();
    reload = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    check("rst_mem_ce", 32'(mem_ce), 32'd1);
    check("rst_mem_wre", 32'(mem_wre), 32'd0);
    check("rst_mem_ad", 32'(mem_ad), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_boot_mode", 32'(boot_mode), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rx_byte_cnt", 32'(rx_byte_cnt), 32'd0);
    m_boot = 1'b1;
    m_err = 1'b0;
    m_cnt = 8'd0;
    fb.delete();
    exp_q.delete();
    pend_done = 0;
    ticks(3);
    rst_n = 1'b1;
    ticks(4);
  endtask

  initial begin
    do_reset();

    // valid load
    tx_q = '{8'hA5, 8'h02, 8'hA1, 8'h00, 8'h78, 8'h00, 8'h19};
    send_all();
    status();
    check("lit_valid_boot", 32'(boot_mode), 32'd0);
    check("lit_valid_err", 32'(err), 32'd0);
    check("lit_valid_cnt", 32'(rx_byte_cnt), 32'd7);
    check("lit_valid_ad", 32'(mem_ad), 32'd1);
    check("lit_valid_din", 32'(mem_din), 32'h0078);
    check("model_valid_boot", 32'(m_boot), 32'd0);

    // reload, then bad checksum
    pulse_reload();
    check("lit_reload_boot", 32'(boot_mode), 32'd1);
    check("lit_reload_ad", 32'(mem_ad), 32'd0);
    tx_q = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h00};
    send_all();
    status();
    check("lit_badchk_din", 32'(mem_din), 32'h1234);
    check("lit_badchk_err", 32'(err), 32'd1);
    check("lit_badchk_boot", 32'(boot_mode), 32'd1);
    tx_q = '{8'hA5};
    send_all();
    status();
    check("lit_sync_clears_err", 32'(err), 32'd0);
    tx_q = '{8'h01, 8'h34, 8'h12, 8'h46};
    send_all();
    status();
    check("lit_goodchk_boot", 32'(boot_mode), 32'd0);

    // leading garbage from a fresh reset
    do_reset();
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h01, 8'h00, 8'h01};
    send_all();
    status();
    check("lit_garbage_cnt", 32'(rx_byte_cnt), 32'd8);
    check("lit_garbage_din", 32'(mem_din), 32'h0001);
    check("lit_garbage_boot", 32'(boot_mode), 32'd0);

    // framing error mid-frame, then recovery
    pulse_reload();
    tx_q = '{8'hA5, 8'h02, 8'h11};
    send_all();
    send_byte(8'h22, 1'b0);
    status();
    check("lit_frm_err", 32'(err), 32'd1);
    check("lit_frm_boot", 32'(boot_mode), 32'd1);
    check("lit_frm_cnt", 32'(rx_byte_cnt), 32'd11);
    tx_q = '{8'hA5, 8'h01, 8'hCD, 8'hAB, 8'h78};
    send_all();
    status();
    check("lit_recover_din", 32'(mem_din), 32'hABCD);
    check("lit_recover_boot", 32'(boot_mode), 32'd0);

    // start-bit glitch, then empty frame
    uart_rx = 1'b0;
    ticks(CPB/2 - 1);
    uart_rx = 1'b1;
    status();
    check("lit_glitch_cnt", 32'(rx_byte_cnt), 32'd16);
    pulse_reload();
    tx_q = '{8'hA5, 8'h00, 8'h00};
    send_all();
    status();
    check("lit_empty_boot", 32'(boot_mode), 32'd0);
    check("lit_empty_cnt", 32'(rx_byte_cnt), 32'd19);

    // reset in the middle of a word, then a fresh load from address 0
    pulse_reload();
    tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
    send_all();
    uart_rx = 1'b0;
    ticks(CPB);
    uart_rx = 1'b0; ticks(CPB);
    uart_rx = 1'b0; ticks(CPB);
    uart_rx = 1'b1; ticks(CPB/2);
    do_reset();
    tx_q = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD};
    send_all();
    status();
    check("lit_final_din", 32'(mem_din), 32'hBEEF);
    check("lit_final_ad", 32'(mem_ad), 32'd0);
    check("lit_final_boot", 32'(boot_mode), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Receives a program image over the board UART (`uart_rx`) and writes it word-by-word into the instruction BSRAM (Gowin_SP single-port).
- Replaces the hard-coded boot table as the boot-time source of program memory.
- Holds `boot_mode` high, so the top-level address mux selects the loader, until a frame with a valid checksum has been written.
- Contains its own 8N1 UART receiver and a frame-parsing FSM.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200, truncated); must be ≥ 4.
- ADDR_W, 11, BSRAM address width.
- DATA_W, 16, BSRAM word width; fixed at 2 bytes per word.

Ports:
- clk  in  1  system clock (27 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- uart_rx  in  1  serial input, idle high, asynchronous to clk.
- reload  in  1  one-cycle pulse; re-enters boot mode from RUN.
- mem_ce  out  1  BSRAM chip enable.
- mem_wre  out  1  BSRAM write enable.
- mem_ad  out  ADDR_W  BSRAM address.
- mem_din  out  DATA_W  BSRAM write data.
- boot_mode  out  1  1 while loading; top-level mux select.
- load_done  out  1  one-cycle pulse when a valid frame completes.
- err  out  1  sticky error flag.
- rx_byte_cnt  out  8  count of bytes received; wraps at 256; for debug/UART echo.

Behaviour:
- Reset state:
  - mem_ce=1, mem_wre=0, mem_ad=0, mem_din=0, boot_mode=1, load_done=0, err=0, rx_byte_cnt=0.
  - Frame FSM in HUNT; receiver in IDLE.
- RX synchronizer: `uart_rx` passes through a 2-flop synchronizer. All receiver decisions use the synchronized value.
- RX receiver FSM (IDLE→START→DATA→STOP):
  - IDLE: a low level moves to START and clears the bit timer.
  - START: at count CLKS_PER_BIT/2, if the line is still low go to DATA; if high it is a glitch, return to IDLE with no byte.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT.
    - Line high: emit a one-cycle byte_valid with the byte, and increment rx_byte_cnt.
    - Line low: framing error. Set err=1 and force the frame FSM to HUNT. No byte_valid.
  - Return to IDLE right after the stop sample. A back-to-back start bit must be caught.
- Frame format: 0xA5 sync, N (word count 0..255), N×{low byte, high byte}, CHK.
  - CHK = 8-bit sum, mod 256, of the 2N data bytes only.
- Frame FSM (advances only on byte_valid, except WRITE):
  - HUNT: byte 0xA5 → LEN, and clear err. Any other byte is ignored.
  - LEN: store N, clear word index and checksum. N=0 → CHK, else → LO.
  - LO: latch low byte, add to checksum → HI.
  - HI: latch high byte, add to checksum → WRITE.
  - WRITE (single cycle, no byte needed):
    - mem_ad=index, mem_din={hi,lo}, mem_wre=1 for exactly one cycle.
    - index+1. If index+1==N → CHK, else → LO.
  - CHK:
    - byte == checksum: → RUN, boot_mode=0 and load_done=1 in the same cycle. load_done drops the next cycle.
    - mismatch: err=1, → HUNT, boot_mode stays 1. Already-written words stay in memory; the next frame overwrites them.
  - RUN: bytes are ignored. A reload pulse → HUNT, boot_mode=1, mem_ad=0.
    - reload in any other state is ignored.
- Write timing: mem_wre is high exactly one cycle per word, on the cycle after the HI byte_valid. Otherwise mem_wre=0. mem_ad and mem_din are held until the next write.
- mem_ce is always 1.
- mem_ad holds `index` (ADDR_W bits, zero-extended). Max address is 254, so no wrap.
- Async reset mid-frame: immediate return to reset values, including boot_mode=1 and index=0. Partial bytes are discarded.

Test Plan:
- Valid load: A5 02 A1 00 78 00 19.
  - Expect mem_wre pulses writing addr0=0x00A1, then addr1=0x0078.
  - Expect boot_mode 1→0 and a single load_done pulse after the 0x19 stop bit; err=0.
- Bad checksum: A5 01 34 12 00 (correct CHK=0x46).
  - Expect addr0=0x1234 written, err=1, boot_mode=1, no load_done.
  - Then the valid frame A5 01 34 12 46 → err clears at the A5, boot_mode=0.
- Leading garbage: 00 FF 5A A5 01 01 00 01.
  - Expect only one write (addr0=0x0001), load_done, and rx_byte_cnt=8.
- Framing error: A5 02 11, then a byte with stop bit=0.
  - Expect err=1, no write, FSM in HUNT; the following valid frame loads normally.
- Glitch and empty frame:
  - rx low for CLKS_PER_BIT/2−1 cycles → no byte.
  - A5 00 00 → zero writes, boot_mode=0.
- Reset/reload:
  - rst_n low mid-word → all outputs back to reset values.
  - After RUN, a reload pulse → boot_mode=1; the next frame reloads from addr0.
